// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: execute-stage <-> HI/LO multiply/divide unit bundle.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_content;
    logic [WIDTH-1:0] rt_content;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             read_req;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, rs_content, rt_content, mthi, mtlo, wdata, read_req,
        input  HI, LO, busy, done, stall
    );

    modport slave (
        input  start, op, rs_content, rt_content, mthi, mtlo, wdata, read_req,
        output HI, LO, busy, done, stall
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative radix-2 multiply/divide engine that owns HI/LO.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// CALC  | one shift-add / shift-subtract iteration per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO written, done pulses next cycle
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      counter;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               start_ok;
    logic               last_iter;
    logic               rs_neg_in;
    logic               rt_neg_in;
    logic [WIDTH-1:0]   rs_mag_in;
    logic [WIDTH-1:0]   rt_mag_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_next_mul;
    logic [2*WIDTH-1:0] acc_next_div;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign start_ok  = (state == IDLE) && bus.start;
    assign last_iter = (counter == CW'(WIDTH - 1));

    // Operand magnitudes; op[0]=0 selects the signed variants.
    always_comb begin
        rs_neg_in = ~bus.op[0] & bus.rs_content[WIDTH-1];
        rt_neg_in = ~bus.op[0] & bus.rt_content[WIDTH-1];
        rs_mag_in = rs_neg_in ? -bus.rs_content : bus.rs_content;
        rt_mag_in = rt_neg_in ? -bus.rt_content : bus.rt_content;
    end

    // One radix-2 iteration for each datapath. For multiply, acc holds
    // {partial product, remaining multiplier bits}; for divide, acc holds
    // {partial remainder, dividend bits becoming quotient bits}.
    always_comb begin
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        acc_next_mul = {mul_sum, acc[WIDTH-1:1]};
        div_shift    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff     = div_shift - {1'b0, opnd};
        div_ge       = (div_shift >= {1'b0, opnd});
        acc_next_div = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Sign correction of the finished magnitude result, plus divide-by-zero override.
    always_comb begin
        res_hi     = '0;
        res_lo     = '0;
        prod_fixed = neg_main ? -acc : acc;
        quo        = acc[WIDTH-1:0];
        rem        = acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            res_hi = prod_fixed[2*WIDTH-1:WIDTH];
            res_lo = prod_fixed[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = rs_q;
            res_lo = '1;
        end else begin
            res_hi = neg_rem  ? -rem : rem;
            res_lo = neg_main ? -quo : quo;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch at start and iteration datapath during CALC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter  <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            rs_q     <= '0;
            opnd     <= '0;
            acc      <= '0;
        end else if (start_ok) begin
            counter  <= '0;
            is_div   <= bus.op[1];
            neg_main <= rs_neg_in ^ rt_neg_in;
            neg_rem  <= rs_neg_in;
            div_zero <= (bus.rt_content == '0);
            rs_q     <= bus.rs_content;
            if (bus.op[1]) begin
                acc  <= {{WIDTH{1'b0}}, rs_mag_in};
                opnd <= rt_mag_in;
            end else begin
                acc  <= {{WIDTH{1'b0}}, rt_mag_in};
                opnd <= rs_mag_in;
            end
        end else if (state == CALC) begin
            counter <= counter + CW'(1);
            acc     <= is_div ? acc_next_div : acc_next_mul;
        end
    end

    // HI/LO: result write at FIX, move writes only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (state == IDLE) begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
        end
    end

    // done pulses for the single cycle after the FIX edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FIX);
        end
    end

    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.stall = bus.busy & (bus.start | bus.mthi | bus.mtlo | bus.read_req);
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed + randomized checks against an arithmetic model.
module tb_hilo_muldiv_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(WIDTH)) bus();

    hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            2'b00: p = sa * sb;
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // mode: 0 plain, 1 mthi mid-op, 2 read_req throughout, 3 second start mid-op,
    //       4 mthi together with start while idle
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mode, input string name);
        logic [63:0] res;
        int n;
        res = model(op, a, b);
        bus.op         = op;
        bus.rs_content = a;
        bus.rt_content = b;
        bus.start      = 1'b1;
        if (mode == 4) begin
            bus.mthi  = 1'b1;
            bus.wdata = 32'h0000_5A5A;
        end
        tick();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        if (mode == 4) exp_hi = 32'h0000_5A5A;
        bus.rs_content = $urandom;
        bus.rt_content = $urandom;
        bus.op         = 2'($urandom);
        n = 0;
        while (bus.busy && n < 60) begin
            n++;
            if (n == 5 || n == 20) begin
                check_eq({name, " hold HI"}, bus.HI, exp_hi);
                check_eq({name, " hold LO"}, bus.LO, exp_lo);
                check_eq({name, " done low"}, bus.done, 1'b0);
            end
            if (mode == 1 && n == 5) begin
                bus.mthi  = 1'b1;
                bus.wdata = 32'h0000_AAAA;
                #1 check_eq({name, " stall mthi"}, bus.stall, 1'b1);
            end
            if (mode == 2) begin
                bus.read_req = 1'b1;
                #1 check_eq({name, " stall read"}, bus.stall, 1'b1);
            end
            if (mode == 3 && n == 5) begin
                bus.start      = 1'b1;
                bus.op         = 2'b01;
                bus.rs_content = 32'h0000_0003;
                bus.rt_content = 32'h0000_0005;
                #1 check_eq({name, " stall start"}, bus.stall, 1'b1);
            end
            tick();
            bus.mthi  = 1'b0;
            bus.start = 1'b0;
        end
        check_eq({name, " busy cycles"}, 64'(n), 64'd33);
        check_eq({name, " done"}, bus.done, 1'b1);
        check_eq({name, " HI"}, bus.HI, res[63:32]);
        check_eq({name, " LO"}, bus.LO, res[31:0]);
        if (mode == 2) check_eq({name, " stall released"}, bus.stall, 1'b0);
        bus.read_req = 1'b0;
        tick();
        check_eq({name, " done pulse"}, bus.done, 1'b0);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.op         = 2'b00;
        bus.rs_content = '0;
        bus.rt_content = '0;
        bus.mthi       = 1'b0;
        bus.mtlo       = 1'b0;
        bus.wdata      = '0;
        bus.read_req   = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        check_eq("reset HI", bus.HI, 32'd0);
        check_eq("reset LO", bus.LO, 32'd0);
        check_eq("reset busy", bus.busy, 1'b0);
        check_eq("reset done", bus.done, 1'b0);
        reset = 1'b0;
        tick();

        bus.read_req = 1'b1;
        #1 check_eq("idle read stall", bus.stall, 1'b0);
        bus.read_req = 1'b0;

        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000_1234;
        tick();
        bus.mthi = 1'b0;
        check_eq("mthi HI", bus.HI, 32'h0000_1234);
        check_eq("mthi LO untouched", bus.LO, 32'd0);
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0000_4321;
        tick();
        bus.mtlo = 1'b0;
        check_eq("mtlo LO", bus.LO, 32'h0000_4321);
        check_eq("mtlo HI untouched", bus.HI, 32'h0000_1234);
        exp_hi = 32'h0000_1234;
        exp_lo = 32'h0000_4321;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu max");
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 0, "mult neg");
        run_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 0, "multu same");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div neg");
        run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 0, "divu 7/2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div ovf");
        run_op(2'b11, 32'h1234_5678, 32'h0000_0000, 0, "divu zero");
        run_op(2'b10, 32'hFFFF_FF00, 32'h0000_0000, 0, "div zero");
        run_op(2'b00, 32'h0001_2345, 32'hFFFF_FF00, 1, "mult mthi");
        run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFF3, 2, "div read");
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0100, 3, "divu restart");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 4, "mult with mthi");

        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom), pick(), pick(), 0, $sformatf("rand%0d", i));
        end

        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0BAD_F00D;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        bus.op         = 2'b10;
        bus.rs_content = 32'h0000_0064;
        bus.rt_content = 32'h0000_0007;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #2 reset = 1'b1;
        #1;
        check_eq("async reset HI", bus.HI, 32'd0);
        check_eq("async reset LO", bus.LO, 32'd0);
        check_eq("async reset busy", bus.busy, 1'b0);
        check_eq("async reset done", bus.done, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("post reset busy", bus.busy, 1'b0);
        exp_hi = '0;
        exp_lo = '0;
        run_op(2'b01, 32'h0000_0003, 32'h0000_0004, 0, "multu 3*4");

        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0000_0005;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check_eq("mt both HI", bus.HI, 32'h0000_0005);
        check_eq("mt both LO", bus.LO, 32'h0000_0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Sequential multiply/divide engine that owns the architectural HI/LO registers. The execute stage issues MULT/MULTU/DIV/DIVU requests to it, MTHI/MTLO writes into it, and MFHI/MFLO reads out of it. It replaces the single-cycle combinational product/quotient with an iterative radix-2 datapath. It reports busy so the pipeline can stall dependent HI/LO accesses.

Parameters:
WIDTH, 32, operand width; iteration count = WIDTH, HI/LO each WIDTH bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse, sampled on clk edge
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_content  input  WIDTH  multiplicand / dividend
rt_content  input  WIDTH  multiplier / divisor
mthi  input  1  write wdata into HI
mtlo  input  1  write wdata into LO
wdata  input  WIDTH  MTHI/MTLO data
read_req  input  1  MFHI/MFLO pending in execute
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register
busy  output  1  operation in progress
done  output  1  one-cycle pulse after HI/LO update
stall  output  1  busy & (start | mthi | mtlo | read_req)

Behaviour:
- Reset (async, any state): HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0. Any in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE + start at edge E0:
  - latch op and operands; signed ops latch magnitudes plus result signs;
  - counter=0, go to CALC, busy=1 after E0.
- CALC: one iteration per cycle, WIDTH cycles (edges E1..E32 for WIDTH=32), then go to FIX.
  - mul: shift-add into 2*WIDTH accumulator;
  - div: restoring shift-subtract, quotient/remainder registers.
- FIX: single edge E33.
  - Apply sign correction and write HI/LO.
  - busy=0 after E33; done=1 for exactly the cycle after E33.
  - Return to IDLE.
  - Result latency: HI/LO valid 33 cycles (WIDTH+1) after the start edge.
- MULT/MULTU: {HI,LO} = full 2*WIDTH product. MULT is two's-complement; MULTU is unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder with dividend's sign. 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU: unsigned LO = quotient, HI = remainder.
- Divisor zero (DIV or DIVU): LO=0xFFFFFFFF, HI=rs_content as latched. Full latency still applies; no exception.
- start while busy: ignored, no restart; stall=1.
- mthi/mtlo while busy: dropped; stall=1. The pipeline retries.
- mthi/mtlo while IDLE: register written at that edge; HI/LO visible next cycle. mthi and mtlo together write both registers.
- start together with mthi/mtlo in IDLE: both accepted. The move writes now; the operation result overwrites HI/LO at FIX.
- read_req: HI/LO outputs always reflect registered values. stall=busy&read_req, so MFHI/MFLO never reads a partial result.
- HI/LO hold their values in CALC; they change only at FIX, mt writes, or reset.
- op values are all defined; operands are latched, so input changes during CALC have no effect.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start pulse -> busy 33 cycles; HI=0xFFFFFFFE, LO=0x00000001; done one cycle after busy falls.
- MULT 0xFFFFFFFE(-2)*0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands as MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678/0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x12345678.
- Busy collisions:
  - mthi wdata=0xAAAA at cycle 5 of a MULT -> dropped, stall=1, HI ends as product.
  - read_req during busy -> stall=1 until busy falls.
  - second start mid-op -> ignored.
- Reset asserted at cycle 10 of DIV -> HI=LO=0, busy=0 immediately (async). A new MULTU 3*4 after release -> LO=12, HI=0. A mthi+mtlo idle write of 0x5 -> HI=LO=5 next cycle.
